// File: rtl/uart_rx_sched_if.sv
// Read-side bus of the UART receive FIFO: show-ahead data, status flags and pop strobe.
interface uart_rx_sched_if;
   logic       rd_en;
   logic [7:0] rd_data;
   logic       empty;
   logic       full;
   logic [2:0] count;

   modport master (output rd_en, input rd_data, empty, full, count);
   modport slave  (input rd_en, output rd_data, empty, full, count);
endinterface

// File: rtl/uart_rx_sched.sv
// UART receiver (8N1, mid-bit sampling) feeding a 4-entry show-ahead FIFO with
// frame-error pulse and sticky overrun flag.
module uart_rx_sched #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           enable,
   input  logic           serial_in,
   input  logic           clear_err,
   output logic           frame_err,
   output logic           overrun,
   output logic           busy,
   uart_rx_sched_if.slave rd
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
   logic [2:0]      bit_idx_q, bit_idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [1:0]      sync_q;
   logic            rx_s;
   logic            push;
   logic            frame_err_q, frame_err_d;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [1:0]      wr_ptr_q, rd_ptr_q;
   logic [2:0]      count_q, count_d;
   logic            overrun_q;
   logic            fifo_empty, fifo_full;
   logic            do_push, do_pop, drop;

   assign rx_s = sync_q[1];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         clk_cnt_q   <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         sync_q      <= 2'b11;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         clk_cnt_q   <= clk_cnt_d;
         bit_idx_q   <= bit_idx_d;
         shift_q     <= shift_d;
         sync_q      <= {sync_q[0], serial_in};
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clk_cnt_d = clk_cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      unique case (state_q)
         StIdle: begin
            clk_cnt_d = '0;
            bit_idx_d = '0;
            if (enable && !rx_s) begin
               state_d = StStart;
            end
         end
         StStart: begin
            clk_cnt_d = clk_cnt_q + 1'b1;
            if (clk_cnt_q == HalfLast) begin
               clk_cnt_d = '0;
               bit_idx_d = '0;
               // A line that is high again at mid-start-bit was only a glitch.
               state_d   = rx_s ? StIdle : StData;
            end
         end
         StData: begin
            clk_cnt_d = clk_cnt_q + 1'b1;
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d          = '0;
               shift_d[bit_idx_q] = rx_s;
               if (bit_idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         StStop: begin
            clk_cnt_d = clk_cnt_q + 1'b1;
            if (clk_cnt_q == BitLast) begin
               clk_cnt_d = '0;
               state_d   = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (!enable && (state_q != StIdle)) begin
         state_d   = StIdle;
         clk_cnt_d = '0;
         bit_idx_d = '0;
      end
   end

   always_comb begin
      busy        = (state_q != StIdle);
      push        = 1'b0;
      frame_err_d = 1'b0;
      if ((state_q == StStop) && enable && (clk_cnt_q == BitLast)) begin
         push        = rx_s;
         frame_err_d = !rx_s;
      end
   end

   assign frame_err = frame_err_q;

   assign fifo_empty = (count_q == 3'd0);
   assign fifo_full  = (count_q == 3'(FIFO_DEPTH));
   assign do_pop     = rd.rd_en && !fifo_empty;
   // At full a simultaneous pop frees the slot the new byte lands in.
   assign do_push    = push && (!fifo_full || do_pop);
   assign drop       = push && fifo_full && !do_pop;

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop) begin
         count_d = count_q + 3'd1;
      end else if (do_pop && !do_push) begin
         count_d = count_q - 3'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
            wr_ptr_q        <= wr_ptr_q + 2'd1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 2'd1;
         end
         count_q <= count_d;
         if (drop) begin
            overrun_q <= 1'b1;
         end else if (clear_err) begin
            overrun_q <= 1'b0;
         end
      end
   end

   assign overrun    = overrun_q;
   assign rd.empty   = fifo_empty;
   assign rd.full    = fifo_full;
   assign rd.count   = count_q;
   assign rd.rd_data = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];

endmodule

// File: doc/uart_rx_sched.md
UART_RX_SCHED -- requirements
Module: uart_rx_sched

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, meaning clock cycles per serial bit; legal values are even integers from 4 to 1024.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning number of received-byte entries; fixed at 4 in this revision.
REQ-003 Port clock  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is a synchronous, active-high reset.
REQ-005 Port enable  input  1  arms reception; when low, the block starts no new frames.
REQ-006 Port serial_in  input  1  is the asynchronous UART line; it idles high.
REQ-007 Port rd_en  input  1  pops the oldest FIFO entry when the FIFO is not empty.
REQ-008 Port clear_err  input  1  clears the sticky overrun flag.
REQ-009 Port rd_data  output  8  is the oldest FIFO byte (show-ahead), 8'h00 when empty.
REQ-010 Port empty, full  output  1 each  are the FIFO status flags.
REQ-011 Port count  output  3  is the number of FIFO entries, 0 to 4.
REQ-012 Port frame_err  output  1  is a 1-cycle pulse on a bad stop bit.
REQ-013 Port overrun  output  1  is a sticky flag set when a byte is dropped.
REQ-014 Port busy  output  1  is high whenever the state is not IDLE.

Function
REQ-015 serial_in SHALL pass through a 2-flop synchronizer (reset value 1); the output rx_s is the only line sample used.
REQ-016 The FSM SHALL use states IDLE, START, DATA and STOP, with an internal counter clk_cnt and bit index bit_idx[2:0].
REQ-017 In IDLE, with enable=1 and rx_s=0, the FSM SHALL go to START with clk_cnt=0.
REQ-018 In START, clk_cnt SHALL increment; at clk_cnt==CLKS_PER_BIT/2-1, rx_s=0 goes to DATA (clk_cnt=0, bit_idx=0), and rx_s=1 returns to IDLE as a glitch with no other effect.
REQ-019 In DATA, at clk_cnt==CLKS_PER_BIT-1, the FSM SHALL load rx_s into shift bit bit_idx (LSB first) and set clk_cnt=0; it goes to STOP if bit_idx==7, otherwise it increments bit_idx.
REQ-020 In STOP, at clk_cnt==CLKS_PER_BIT-1, the FSM SHALL return to IDLE; rx_s=1 pushes the byte, and rx_s=0 pulses frame_err for exactly one cycle with no push.
REQ-021 enable=0 in START, DATA or STOP SHALL abort the frame: IDLE on the next cycle, byte discarded, no frame_err.
REQ-022 A push SHALL be visible the cycle after the final STOP-sample edge: count+1, empty=0, and rd_data equal to the byte if the FIFO was empty.
REQ-023 rd_en with empty=1 SHALL be ignored, with no pointer or count change.
REQ-024 A push with full=1 and no pop in the same cycle SHALL drop the byte and set overrun; FIFO contents stay unchanged.
REQ-025 A push and a pop in the same cycle SHALL both occur, leaving count unchanged; at full this SHALL NOT set overrun.
REQ-026 FIFO pointers SHALL be 2 bits and wrap from 3 to 0; full is (count==4) and empty is (count==0).
REQ-027 clear_err=1 SHALL clear overrun; if an overrun event occurs in the same cycle, set wins.
REQ-028 The total frame length SHALL be CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles from the first IDLE-to-START transition to the return to IDLE.

Reset
REQ-029 While reset=1, the block SHALL set state=IDLE, clk_cnt=0, bit_idx=0, synchronizer=2'b11, pointers=0, count=0, empty=1, full=0, rd_data=8'h00, frame_err=0, overrun=0 and busy=0.
REQ-030 reset SHALL take priority over all other inputs, including mid-frame; a frame in progress is discarded.

Verification
REQ-031 CLKS_PER_BIT=16, enable=1, send 0xA5 with a valid stop bit -> count=1, rd_data=8'hA5, frame_err never set; rd_en then gives empty=1.
REQ-032 serial_in low for 4 cycles, then high -> busy rises then falls, the FSM returns to IDLE, count=0, and no frame_err.
REQ-033 Send 0x3C with stop bit=0 -> frame_err high for exactly 1 cycle, count stays 0.
REQ-034 Send 0x01,0x02,0x03,0x04,0x05 with no reads -> full=1 after the 4th byte, overrun=1 after the 5th, and pops return 01,02,03,04; clear_err then gives overrun=0.
REQ-035 Fill with 4 bytes, then assert rd_en in the push cycle of byte 0x55 -> count=4, overrun=0, and the last pop returns 0x55.
REQ-036 Assert reset during DATA bit 3, then send 0x81 -> busy=0 after reset, and only 0x81 is received.
